// File: rtl/stage4_vmem_sequencer_if.sv
// Execute <-> vector memory sequencer <-> data bus signal bundle.
// master: execute/bus environment side; slave: the sequencer.
interface stage4_vmem_sequencer_if #(
  parameter int unsigned MAX_VL = 32,
  parameter int unsigned IW     = $clog2(MAX_VL)
);
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic          req_load;
  logic [31:0]   req_base;
  logic [31:0]   req_stride;
  logic [IW:0]   req_vl;
  logic [1:0]    req_sew;
  logic [4:0]    req_vd;
  logic [IW-1:0] st_idx;
  logic [31:0]   st_data;

  logic          dbus_ren;
  logic          dbus_wen;
  logic [31:0]   dbus_addr;
  logic [31:0]   dbus_wdata;
  logic [3:0]    dbus_byte_en;
  logic          dbus_busy;
  logic [31:0]   dbus_rdata;

  logic          vwb_wen;
  logic [4:0]    vwb_vd;
  logic [IW-1:0] vwb_eidx;
  logic [31:0]   vwb_data;

  logic          done;
  logic          fault;
  logic [IW-1:0] fault_eidx;

  modport master (
    output flush, req_valid, req_load, req_base, req_stride, req_vl, req_sew, req_vd, st_data,
           dbus_busy, dbus_rdata,
    input  req_ready, st_idx, dbus_ren, dbus_wen, dbus_addr, dbus_wdata, dbus_byte_en,
           vwb_wen, vwb_vd, vwb_eidx, vwb_data, done, fault, fault_eidx
  );

  modport slave (
    input  flush, req_valid, req_load, req_base, req_stride, req_vl, req_sew, req_vd, st_data,
           dbus_busy, dbus_rdata,
    output req_ready, st_idx, dbus_ren, dbus_wen, dbus_addr, dbus_wdata, dbus_byte_en,
           vwb_wen, vwb_vd, vwb_eidx, vwb_data, done, fault, fault_eidx
  );
endinterface

// File: rtl/stage4_vmem_sequencer.sv
// Memory-stage vector load/store sequencer: splits a strided op into per-element bus accesses.
// Optional STAGE4_VMEM_PERF_EN adds perf_elems / perf_wait counters.
module stage4_vmem_sequencer #(
  parameter int unsigned MAX_VL = 32,
  parameter int unsigned WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  stage4_vmem_sequencer_if.slave bus
`ifdef STAGE4_VMEM_PERF_EN
  ,
  output logic [31:0]            perf_elems,
  output logic [31:0]            perf_wait
`endif
);
  localparam int unsigned IW = $clog2(MAX_VL);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StFault} state_e;

  state_e              state_q, state_d;
  logic                load_q;
  logic [31:0]         addr_q;
  logic [31:0]         stride_q;
  logic [IW:0]         vl_q;
  logic [1:0]          sew_q;
  logic [4:0]          vd_q;
  logic [IW-1:0]       idx_q;

  logic                vwb_wen_q;
  logic [4:0]          vwb_vd_q;
  logic [IW-1:0]       vwb_eidx_q;
  logic [WORD_W-1:0]   vwb_data_q;

  logic [1:0]          off;
  logic                misaligned;
  logic                access_ok;
  logic                complete;
  logic                last_elem;
  logic                accept;
  logic [IW:0]         vl_last;
  logic [3:0]          base_en;
  logic [WORD_W-1:0]   wdata;
  logic [WORD_W-1:0]   shifted;
  logic [WORD_W-1:0]   load_elem;

  assign off       = addr_q[1:0];
  assign vl_last   = vl_q - {{IW{1'b0}}, 1'b1};
  assign last_elem = ({1'b0, idx_q} == vl_last);
  assign accept    = (state_q == StIdle) && bus.req_valid && !bus.flush;
  // Misaligned elements never strobe the bus; flush gates strobes combinationally.
  assign access_ok = (state_q == StAccess) && !misaligned && !bus.flush;
  assign complete  = access_ok && !bus.dbus_busy;

  always_comb begin
    case (sew_q)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    base_en   = 4'b1111;
    wdata     = bus.st_data;
    shifted   = bus.dbus_rdata >> {off, 3'b000};
    load_elem = shifted;
    case (sew_q)
      2'b00: begin
        base_en   = 4'b0001;
        wdata     = {4{bus.st_data[7:0]}};
        load_elem = {{(WORD_W-8){1'b0}}, shifted[7:0]};
      end
      2'b01: begin
        base_en   = 4'b0011;
        wdata     = {2{bus.st_data[15:0]}};
        load_elem = {{(WORD_W-16){1'b0}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = (bus.req_vl == '0) ? StDone : StAccess;
      end
      StAccess: begin
        if (misaligned)                state_d = StFault;
        else if (complete && last_elem) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q     <= 1'b0;
      addr_q     <= '0;
      stride_q   <= '0;
      vl_q       <= '0;
      sew_q      <= '0;
      vd_q       <= '0;
      idx_q      <= '0;
      vwb_wen_q  <= 1'b0;
      vwb_vd_q   <= '0;
      vwb_eidx_q <= '0;
      vwb_data_q <= '0;
    end else begin
      if (accept) begin
        load_q   <= bus.req_load;
        addr_q   <= bus.req_base;
        stride_q <= bus.req_stride;
        vl_q     <= bus.req_vl;
        sew_q    <= bus.req_sew;
        vd_q     <= bus.req_vd;
        idx_q    <= '0;
      end else if (complete && !last_elem) begin
        idx_q  <= idx_q + IW'(1);
        addr_q <= addr_q + stride_q;
      end
      vwb_wen_q <= complete && load_q;
      if (complete && load_q) begin
        vwb_vd_q   <= vd_q;
        vwb_eidx_q <= idx_q;
        vwb_data_q <= load_elem;
      end
    end
  end

  assign bus.req_ready    = (state_q == StIdle);
  assign bus.st_idx       = idx_q;
  assign bus.dbus_ren     = access_ok && load_q;
  assign bus.dbus_wen     = access_ok && !load_q;
  assign bus.dbus_addr    = {addr_q[31:2], 2'b00};
  assign bus.dbus_wdata   = wdata;
  assign bus.dbus_byte_en = base_en << off;
  // A flush also swallows a writeback still waiting in the output register.
  assign bus.vwb_wen      = vwb_wen_q && !bus.flush;
  assign bus.vwb_vd       = vwb_vd_q;
  assign bus.vwb_eidx     = vwb_eidx_q;
  assign bus.vwb_data     = vwb_data_q;
  assign bus.done         = (state_q == StDone) && !bus.flush;
  assign bus.fault        = (state_q == StFault) && !bus.flush;
  assign bus.fault_eidx   = bus.fault ? idx_q : '0;

`ifdef STAGE4_VMEM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_elems <= '0;
      perf_wait  <= '0;
    end else begin
      if (complete)                  perf_elems <= perf_elems + 32'd1;
      if (access_ok && bus.dbus_busy) perf_wait  <= perf_wait + 32'd1;
    end
  end
`endif
endmodule
